// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline skid stage.
package pipe_pkg;

    // Holding state of the stage: nothing, head only, or head plus skid.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } pipe_state_t;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Increment unless already at the maximum value.
    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register; only reset clears it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Parametrised valid/ready pipeline stage with optional 2-entry skid buffer,
// flush, global stall, zeroed bubble control and a backpressure counter.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int CTRL_W  = 4,
    parameter int CNT_W   = 16,
    parameter int SKID_EN = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              stall_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occupancy_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    localparam int ENT_W = CTRL_W + DATA_W;

    pipe_state_t state_q, state_d;
    logic [ENT_W-1:0] head_q, head_d;
    logic [ENT_W-1:0] skid_q, skid_d;
    logic [1:0]       occ_q, occ_d;

    logic             head_valid;
    logic             accept;
    logic             pop;
    logic [ENT_W-1:0] in_entry;

    assign in_entry   = {ctrl_i, data_i};
    assign head_valid = (state_q != ST_EMPTY);

    // Stall hides the head from downstream; control reads zero on a bubble.
    assign valid_o = head_valid & ~stall_i;
    assign ctrl_o  = valid_o ? head_q[ENT_W-1:DATA_W] : '0;
    assign data_o  = head_q[DATA_W-1:0];

    generate
        if (SKID_EN != 0) begin : g_skid_ready
            // Ready depends on registered state only, breaking the ready_i path.
            assign ready_o = (state_q != ST_SKID) & ~stall_i;
        end else begin : g_pass_ready
            // Single register: can take a new entry if empty or the head leaves now.
            assign ready_o = (~head_valid | ready_i) & ~stall_i;
        end
    endgenerate

    assign accept = valid_i & ready_o;
    assign pop    = valid_o & ready_i;

    // Next-state, head/skid mux and occupancy; flush overrides the handshake.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_FULL;
                        head_d  = in_entry;
                    end
                end
                ST_FULL: begin
                    if (accept && pop) begin
                        head_d = in_entry;
                    end else if (accept && (SKID_EN != 0)) begin
                        state_d = ST_SKID;
                        skid_d  = in_entry;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (pop) begin
                        state_d = ST_FULL;
                        head_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        case (state_d)
            ST_FULL: occ_d = OCC_ONE;
            ST_SKID: occ_d = OCC_TWO;
            default: occ_d = OCC_EMPTY;
        endcase
    end

    // State and entry registers; payload registers survive flush untouched.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            occ_q   <= OCC_EMPTY;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            occ_q   <= occ_d;
        end
    end

    assign occupancy_o = occ_q;

    // Counts cycles where a held entry is not taken, including stalled cycles.
    sat_counter #(
        .W(CNT_W)
    ) u_stall_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc_i (head_valid & ~pop),
        .cnt_o (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Bench for pipe_skid_stage: two instances (skid, and no-skid with a 2-bit
// counter) share stimulus and are compared against a FIFO-level model.
module tb_pipe_skid_stage;

    logic clk = 1'b0;
    logic rst_i = 1'b1, flush_i = 1'b0, stall_i = 1'b0;
    logic valid_i = 1'b0, ready_i = 1'b0;
    logic [3:0]  ctrl_i = '0;
    logic [31:0] data_i = '0;

    logic        ready0, valid0, ready1, valid1;
    logic [3:0]  ctrl0, ctrl1;
    logic [31:0] data0, data1;
    logic [1:0]  occ0, occ1;
    logic [15:0] cnt0;
    logic [1:0]  cnt1;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipe_skid_stage #(.DATA_W(32), .CTRL_W(4), .CNT_W(16), .SKID_EN(1)) dut0 (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
        .valid_i(valid_i), .ready_o(ready0), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(valid0), .ready_i(ready_i), .ctrl_o(ctrl0), .data_o(data0),
        .occupancy_o(occ0), .stall_cnt_o(cnt0)
    );

    pipe_skid_stage #(.DATA_W(32), .CTRL_W(4), .CNT_W(2), .SKID_EN(0)) dut1 (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .stall_i(stall_i),
        .valid_i(valid_i), .ready_o(ready1), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(valid1), .ready_i(ready_i), .ctrl_o(ctrl1), .data_o(data1),
        .occupancy_o(occ1), .stall_cnt_o(cnt1)
    );

    // Model: per instance a list of up to 2 held entries and a stall count.
    int          m_n [2];
    logic [31:0] m_d0[2], m_d1[2];
    logic [3:0]  m_c0[2], m_c1[2];
    int          m_sc[2];
    logic        m_ok = 1'b0;

    function automatic logic exp_ready(input int i, input int n);
        if (i == 0) return (n < 2) && !stall_i;
        return ((n == 0) || ready_i) && !stall_i;
    endfunction

    function automatic int cnt_max(input int i);
        return (i == 0) ? 65535 : 3;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Model update on each rising edge from the inputs seen at that edge.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            automatic int          n  = m_n[i];
            automatic int          sc = m_sc[i];
            automatic logic [31:0] d0 = m_d0[i], d1 = m_d1[i];
            automatic logic [3:0]  c0 = m_c0[i], c1 = m_c1[i];
            automatic logic        vo = (n > 0) && !stall_i;
            automatic logic        pp = vo && ready_i;
            automatic logic        ac = valid_i && exp_ready(i, n);
            if (rst_i) begin
                n  = 0;
                sc = 0;
            end else begin
                if ((n > 0) && !pp && (sc < cnt_max(i))) sc++;
                if (flush_i) begin
                    n = 0;
                end else begin
                    if (pp) begin
                        d0 = d1; c0 = c1; n--;
                    end
                    if (ac) begin
                        if (n == 0) begin d0 = data_i; c0 = ctrl_i; end
                        else        begin d1 = data_i; c1 = ctrl_i; end
                        n++;
                    end
                end
            end
            m_n[i]  <= n;
            m_sc[i] <= sc;
            m_d0[i] <= d0; m_d1[i] <= d1;
            m_c0[i] <= c0; m_c1[i] <= c1;
        end
        if (rst_i) m_ok <= 1'b1;
    end

    // Compare both instances against the model mid-cycle.
    always @(negedge clk) begin
        if (m_ok) begin
            for (int i = 0; i < 2; i++) begin
                automatic int   n  = m_n[i];
                automatic logic ev = (n > 0) && !stall_i;
                automatic logic [3:0] ec = ev ? m_c0[i] : 4'h0;
                check($sformatf("dut%0d valid_o", i), (i == 0) ? 32'(valid0) : 32'(valid1), 32'(ev));
                check($sformatf("dut%0d ready_o", i), (i == 0) ? 32'(ready0) : 32'(ready1), 32'(exp_ready(i, n)));
                check($sformatf("dut%0d ctrl_o", i), (i == 0) ? 32'(ctrl0) : 32'(ctrl1), 32'(ec));
                check($sformatf("dut%0d occupancy_o", i), (i == 0) ? 32'(occ0) : 32'(occ1), 32'(n));
                check($sformatf("dut%0d stall_cnt_o", i), (i == 0) ? 32'(cnt0) : 32'(cnt1), 32'(m_sc[i]));
                if (n > 0)
                    check($sformatf("dut%0d data_o", i), (i == 0) ? data0 : data1, m_d0[i]);
            end
        end
    end

    task automatic drv(input logic v, input logic [3:0] c, input logic [31:0] d,
                       input logic r, input logic f, input logic s);
        valid_i = v; ctrl_i = c; data_i = d; ready_i = r; flush_i = f; stall_i = s;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        step(); step();
        rst_i = 1'b0;
        // Reset state
        drv(0, 0, 0, 0, 0, 0); #2;
        check("reset valid_o", 32'(valid0), 0);
        check("reset ready_o", 32'(ready0), 1);
        check("reset ctrl_o", 32'(ctrl0), 0);
        check("reset data_o", data0, 0);
        check("reset occupancy_o", 32'(occ0), 0);
        check("reset stall_cnt_o", 32'(cnt0), 0);
        check("reset stall_cnt_o dut1", 32'(cnt1), 0);
        step();
        // Streaming 1,2,3
        drv(1, 1, 1, 1, 0, 0); #2; check("stream ready", 32'(ready0), 1); step();
        drv(1, 2, 2, 1, 0, 0); #2; check("stream d1", data0, 1); step();
        drv(1, 3, 3, 1, 0, 0); #2; check("stream d2", data0, 2); step();
        drv(0, 0, 0, 1, 0, 0); #2; check("stream d3", data0, 3); check("stream occ", 32'(occ0), 1); step();
        #2; check("stream drained", 32'(valid0), 0); step();
        // Backpressure A,B
        drv(1, 5, 32'hA, 0, 0, 0); #2; check("bp ready empty", 32'(ready0), 1); step();
        drv(1, 6, 32'hB, 0, 0, 0); #2; check("bp ready full", 32'(ready0), 1); step();
        drv(0, 0, 0, 0, 0, 0); #2;
        check("bp occ two", 32'(occ0), 2); check("bp ready skid", 32'(ready0), 0); check("bp head A", data0, 32'hA);
        step();
        drv(0, 0, 0, 1, 0, 0); #2; check("bp out A", data0, 32'hA); check("bp ctrl A", 32'(ctrl0), 5); step();
        #2; check("bp out B", data0, 32'hB); check("bp occ one", 32'(occ0), 1); step();
        #2; check("bp empty", 32'(occ0), 0); check("bp cnt", 32'(cnt0), 2);
        // Bubble control with ctrl_i=F
        drv(0, 4'hF, 0, 1, 0, 0); #2; check("bubble ctrl", 32'(ctrl0), 0); check("bubble valid", 32'(valid0), 0); step();
        // Flush in SKID with C offered
        drv(1, 1, 32'h11, 0, 0, 0); step();
        drv(1, 2, 32'h22, 0, 0, 0); step();
        drv(0, 0, 0, 0, 0, 0); #2; check("pre-flush occ", 32'(occ0), 2);
        drv(1, 3, 32'hCC, 0, 1, 0); #1; step();
        drv(0, 0, 0, 1, 0, 0); #2;
        check("flush occ", 32'(occ0), 0); check("flush valid", 32'(valid0), 0); check("flush cnt kept", 32'(cnt0), 4);
        step(); #2; check("flush C gone", 32'(valid0), 0); step();
        // Stall three cycles with one entry held
        drv(1, 3, 32'h55, 0, 0, 0); step();
        drv(0, 0, 0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            #2;
            check("stall valid", 32'(valid0), 0); check("stall ready", 32'(ready0), 0); check("stall data", data0, 32'h55);
            step();
        end
        drv(0, 0, 0, 1, 0, 0); #2;
        check("resume data", data0, 32'h55); check("resume ctrl", 32'(ctrl0), 3); check("stall cnt +3", 32'(cnt0), 7);
        step(); #2; check("resume empty", 32'(occ0), 0);
        // Saturation on CNT_W=2, combinational ready with SKID_EN=0
        drv(1, 1, 32'h77, 0, 0, 0); step();
        drv(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 6; k++) step();
        #2; check("sat cnt dut1", 32'(cnt1), 3); check("noskid ready low", 32'(ready1), 0);
        ready_i = 1'b1; #1; check("noskid ready follows", 32'(ready1), 1);
        step(); step(); step();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
